bram_copy_engine: RTL and testbench
===================================

Name: bram_copy_engine

Overview:
- Initiator for the dual-port BRAM request interface: copies a block of words from a source range to a destination range inside one dual_port_BRAM instance.
- Reads on BRAM port 1 and writes on BRAM port 2, so steady-state throughput is one word per cycle.
- Sits beside a core or test harness as a simple memory-move / initialisation helper; controlled by a start/busy/done handshake.

Parameters:
- DATA_WIDTH, 32, BRAM word width.
- ADDR_WIDTH, 8, BRAM word-address width; memory depth is 2^ADDR_WIDTH.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request pulse; sampled only in IDLE.
- src_addr  in  ADDR_WIDTH  first source word address; captured on accepted start.
- dst_addr  in  ADDR_WIDTH  first destination word address; captured on accepted start.
- length  in  ADDR_WIDTH+1  number of words to copy, 0..2^ADDR_WIDTH; captured on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the final write has been issued.
- readEnable_1  out  1  BRAM port 1 read strobe.
- address_1  out  ADDR_WIDTH  BRAM port 1 address.
- readData_1  in  DATA_WIDTH  BRAM port 1 read data; valid the cycle after readEnable_1 is sampled.
- writeEnable_2  out  1  BRAM port 2 write strobe.
- address_2  out  ADDR_WIDTH  BRAM port 2 address.
- writeData_2  out  DATA_WIDTH  BRAM port 2 write data.

Behaviour:
- Reset (asynchronous, active-low) forces the following, including mid-transfer; the transfer is discarded and the engine returns to IDLE:
  - busy=0, done=0
  - all enables=0
  - all address and writeData outputs=0
- FSM states:
  - IDLE:
    - start with length!=0: capture src/dst/length, zero the counters, go to READ.
    - start with length==0: done pulses the next cycle, busy stays 0, no BRAM access.
  - READ:
    - Each cycle: readEnable_1=1, address_1=src+rd_cnt.
    - A read issued in cycle N gives a write in cycle N+1: writeEnable_2=1, address_2=dst+wr_cnt, writeData_2=readData_1 (combinational pass of BRAM output; no extra register).
    - When the last read issues, go to DRAIN.
  - DRAIN: readEnable_1=0; issue the final write; assert done and go to IDLE.
- busy=1 in READ and DRAIN; done asserts in the same cycle as the final writeEnable_2.
- Latency: N-word copy from accepted start:
  - first read at cycle +1;
  - last write and done at cycle +N+1;
  - busy high N+1 cycles.
- Address arithmetic is modulo 2^ADDR_WIDTH; src/dst ranges wrap past the top of memory.
- length=2^ADDR_WIDTH copies the whole memory.
- start while busy is ignored (no queueing); inputs are ignored outside IDLE.
- Overlap rules:
  - src==dst or dst<src overlapping ranges: correct (forward copy).
  - dst in (src, src+length): result undefined; caller must avoid.
- Outputs are registered except writeData_2.
- Enables and addresses are held at 0 when the port is not in use.

Optional Feature:
- BRAM_COPY_FILL_EN adds two input ports: fill (1) and fill_data (DATA_WIDTH), both captured on start.
- With the macro and fill=1: no reads, readEnable_1 stays 0, and writes of fill_data start at cycle +1. The N-word fill finishes at +N with busy high N cycles.
- With the macro and fill=0: behaviour identical to the non-macro build.
- Without the macro: ports absent; copy-only behaviour.

Decomposition:
- Shared package bram_copy_pkg holds:
  - FSM state encoding: IDLE, READ, DRAIN;
  - the LENGTH_WIDTH = ADDR_WIDTH+1 derivation.
- No sub-module; one flat module. The FSM and the rd_cnt/wr_cnt counters are one unit.

Test Plan:
- Preload words 0..3 = 10,11,12,13; start src=0 dst=16 length=4 -> writes at 16..19 = 10..13 on consecutive cycles; done at start+5; busy high 5 cycles.
- length=0 -> done pulses next cycle, busy never asserts, no enables.
- Wrap test: src=254 dst=2 length=4 (ADDR_WIDTH=8) -> reads 254,255,0,1; words 2..5 receive their data.
- start pulsed during busy with different params -> ignored; original copy completes unchanged; one done.
- Reset mid-copy after 2 of 8 words -> enables drop immediately, busy=0; next start with length=3 runs normally.
- With BRAM_COPY_FILL_EN, fill=1 fill_data=0xA5A5A5A5 dst=32 length=3 -> words 32..34 written; readEnable_1 never high; done at start+3.

Source files
------------

// File: rtl/bram_copy_pkg.sv
// bram_copy_pkg: shared FSM encoding and width helper for bram_copy_engine.
package bram_copy_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_e;

    // A length spans 0..2^addr_width inclusive, so it needs one bit more than an address.
    function automatic int length_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/bram_copy_engine.sv
// bram_copy_engine: copies (or, with BRAM_COPY_FILL_EN defined, fills) a block of words
// inside one dual-port BRAM. Reads on port 1, writes on port 2, one word per cycle.
// Ports: clock_i/reset_ni (async active-low); start_i, src_addr_i, dst_addr_i, length_i
// (and fill_i, fill_data_i when BRAM_COPY_FILL_EN is defined) request a transfer;
// busy_o/done_o report progress; readEnable_1_o/address_1_o/readData_1_i drive BRAM port 1;
// writeEnable_2_o/address_2_o/writeData_2_o drive BRAM port 2.
module bram_copy_engine
    import bram_copy_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    localparam int LENGTH_WIDTH = length_width(ADDR_WIDTH)
) (
    input  logic                    clock_i,
    input  logic                    reset_ni,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH-1:0]   src_addr_i,
    input  logic [ADDR_WIDTH-1:0]   dst_addr_i,
    input  logic [LENGTH_WIDTH-1:0] length_i,
`ifdef BRAM_COPY_FILL_EN
    input  logic                    fill_i,
    input  logic [DATA_WIDTH-1:0]   fill_data_i,
`endif
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    readEnable_1_o,
    output logic [ADDR_WIDTH-1:0]   address_1_o,
    input  logic [DATA_WIDTH-1:0]   readData_1_i,
    output logic                    writeEnable_2_o,
    output logic [ADDR_WIDTH-1:0]   address_2_o,
    output logic [DATA_WIDTH-1:0]   writeData_2_o
);

    localparam logic [LENGTH_WIDTH-1:0] ONE = LENGTH_WIDTH'(1);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   src_q, src_d, dst_q, dst_d;
    logic [LENGTH_WIDTH-1:0] len_q, len_d, rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic                    fill_q, fill_d;
    logic [DATA_WIDTH-1:0]   fill_data_q, fill_data_d;
    logic                    busy_q, busy_d, done_q, done_d;
    logic                    re_q, re_d, we_q, we_d;
    logic [ADDR_WIDTH-1:0]   a1_q, a1_d, a2_q, a2_d;
    logic                    start_fill;
    logic [DATA_WIDTH-1:0]   start_fill_data;
    logic                    last_beat;

`ifdef BRAM_COPY_FILL_EN
    assign start_fill      = fill_i;
    assign start_fill_data = fill_data_i;
`else
    assign start_fill      = 1'b0;
    assign start_fill_data = '0;
`endif

    // Copy ends once the final read has issued; fill has no reads, so it ends on the
    // cycle that schedules the final write.
    assign last_beat = fill_q ? (wr_cnt_q + ONE == len_q) : (rd_cnt_q == len_q);

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        len_d       = len_q;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        fill_d      = fill_q;
        fill_data_d = fill_data_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        re_d        = 1'b0;
        a1_d        = '0;
        we_d        = 1'b0;
        a2_d        = '0;
        case (state_q)
            IDLE: begin
                if (start_i && length_i == '0) begin
                    done_d = 1'b1;
                end else if (start_i) begin
                    src_d       = src_addr_i;
                    dst_d       = dst_addr_i;
                    len_d       = length_i;
                    fill_d      = start_fill;
                    fill_data_d = start_fill_data;
                    busy_d      = 1'b1;
                    rd_cnt_d    = start_fill ? '0 : ONE;
                    wr_cnt_d    = start_fill ? ONE : '0;
                    // Fill skips the read stage, so its first write is scheduled right away.
                    re_d        = !start_fill;
                    a1_d        = start_fill ? '0 : src_addr_i;
                    we_d        = start_fill;
                    a2_d        = start_fill ? dst_addr_i : '0;
                    done_d      = start_fill && length_i == ONE;
                    state_d     = (start_fill && length_i == ONE) ? DRAIN : READ;
                end
            end
            READ: begin
                busy_d   = 1'b1;
                we_d     = 1'b1;
                a2_d     = dst_q + wr_cnt_q[ADDR_WIDTH-1:0];
                wr_cnt_d = wr_cnt_q + ONE;
                done_d   = last_beat;
                state_d  = last_beat ? DRAIN : READ;
                if (!last_beat && !fill_q) begin
                    re_d     = 1'b1;
                    a1_d     = src_q + rd_cnt_q[ADDR_WIDTH-1:0];
                    rd_cnt_d = rd_cnt_q + ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            fill_q      <= 1'b0;
            fill_data_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            re_q        <= 1'b0;
            a1_q        <= '0;
            we_q        <= 1'b0;
            a2_q        <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            fill_q      <= fill_d;
            fill_data_q <= fill_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            re_q        <= re_d;
            a1_q        <= a1_d;
            we_q        <= we_d;
            a2_q        <= a2_d;
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign readEnable_1_o  = re_q;
    assign address_1_o     = a1_q;
    assign writeEnable_2_o = we_q;
    assign address_2_o     = a2_q;
    // Port-1 read data flows straight to port 2; forced to zero when no write is issued.
    assign writeData_2_o   = !we_q ? '0 : fill_q ? fill_data_q : readData_1_i;

endmodule

// File: tb/tb_bram_copy_engine.sv
// tb_bram_copy_engine: randomized scoreboard bench for bram_copy_engine with a BRAM model.
module tb_bram_copy_engine;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] src = '0, dst = '0;
    logic [AW:0]   len = '0;
    logic          busy, done, re, we;
    logic [AW-1:0] a1, a2;
    logic [DW-1:0] rd_data, wd;
`ifdef BRAM_COPY_FILL_EN
    logic          fill = 1'b0;
    logic [DW-1:0] fill_data = '0;
`endif

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic          pl_init = 1'b0, pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    ev_t exp_rd[$], exp_wr[$];
    int  exp_done[$];
    int  busy_lo = 1, busy_hi = 0;
    int  cyc = 0;
    int  checks = 0, errors = 0;

    bram_copy_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock_i(clk),
        .reset_ni(rst_n),
        .start_i(start),
        .src_addr_i(src),
        .dst_addr_i(dst),
        .length_i(len),
`ifdef BRAM_COPY_FILL_EN
        .fill_i(fill),
        .fill_data_i(fill_data),
`endif
        .busy_o(busy),
        .done_o(done),
        .readEnable_1_o(re),
        .address_1_o(a1),
        .readData_1_i(rd_data),
        .writeEnable_2_o(we),
        .address_2_o(a2),
        .writeData_2_o(wd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_word(input int i);
        return 32'(i) * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    // BRAM model: registered read, write on port 2.
    always @(posedge clk) begin
        if (pl_init)
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
        if (pl_en) mem[pl_addr] <= pl_data;
        if (re) rd_data <= mem[a1];
        if (we) mem[a2] <= wd;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: forward element-by-element copy (or fill) of the block. Only events
    // in cycles up to c0+cut are expected, which models a reset cutting the transfer short.
    task automatic expect_xfer(input int s, input int d, input int n, input bit f,
                               input logic [DW-1:0] fd, input int c0, input int cut);
        int lat = f ? 1 : 2;
        int last = c0 + lat + n - 1;
        logic [DW-1:0] v;
        busy_lo = c0 + 1;
        if (n == 0) begin
            busy_hi = c0;
            exp_done.push_back(c0 + 1);
            return;
        end
        for (int i = 0; i < n; i++) begin
            if (!f && i + 1 <= cut) exp_rd.push_back('{cyc: c0 + 1 + i, addr: AW'(s + i), data: '0});
            if (lat + i <= cut) begin
                v = f ? fd : ref_mem[AW'(s + i)];
                ref_mem[AW'(d + i)] = v;
                exp_wr.push_back('{cyc: c0 + lat + i, addr: AW'(d + i), data: v});
            end
        end
        if (last <= c0 + cut) exp_done.push_back(last);
        busy_hi = (last < c0 + cut) ? last : c0 + cut;
    endtask

    task automatic drive_junk();
        start = 1'b0;
        src   = AW'($urandom);
        dst   = AW'($urandom);
        len   = (AW + 1)'($urandom);
`ifdef BRAM_COPY_FILL_EN
        fill      = 1'($urandom);
        fill_data = $urandom;
`endif
    endtask

    task automatic issue(input int s, input int d, input int n, input bit f,
                         input logic [DW-1:0] fd, input int cut, output int c0);
        @(posedge clk); #1;
        c0    = cyc;
        start = 1'b1;
        src   = AW'(s);
        dst   = AW'(d);
        len   = (AW + 1)'(n);
`ifdef BRAM_COPY_FILL_EN
        fill      = f;
        fill_data = fd;
`endif
        expect_xfer(s, d, n, f, fd, c0, cut);
        @(posedge clk); #1;
        drive_junk();
    endtask

    task automatic wait_idle(input string nm);
        int bad = 0;
        for (int i = 0; i < 600 && (exp_done.size() + exp_wr.size() + exp_rd.size()) != 0; i++)
            @(posedge clk);
        chk({nm, "_pending_events"}, exp_done.size() + exp_wr.size() + exp_rd.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk({nm, "_mem_mismatch_words"}, bad, 0);
    endtask

    task automatic run(input int s, input int d, input int n, input bit f,
                       input logic [DW-1:0] fd, input string nm);
        int c0;
        issue(s, d, n, f, fd, 1 << 30, c0);
        wait_idle(nm);
    endtask

    task automatic preload(input int a, input logic [DW-1:0] v);
        @(posedge clk); #1;
        pl_en   = 1'b1;
        pl_addr = AW'(a);
        pl_data = v;
        ref_mem[a] = v;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    function automatic bit illegal(input int s, input int d, input int n);
        int off = (d - s) & (DEPTH - 1);
        return off != 0 && off < n;
    endfunction

    // Monitor: compares every DUT output against the scoreboard on the falling edge.
    initial forever begin
        ev_t e;
        int  c;
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_re", re, 0);
            chk("rst_we", we, 0);
            chk("rst_a1", a1, 0);
            chk("rst_a2", a2, 0);
            chk("rst_wd", wd, 0);
        end else begin
            chk("busy", busy, cyc >= busy_lo && cyc <= busy_hi);
            if (re && exp_rd.size() == 0) chk("rd_unexpected", re, 0);
            else if (re) begin
                e = exp_rd.pop_front();
                chk("rd_cycle", cyc, e.cyc);
                chk("rd_addr", a1, e.addr);
            end else chk("rd_addr_idle", a1, 0);
            if (we && exp_wr.size() == 0) chk("wr_unexpected", we, 0);
            else if (we) begin
                e = exp_wr.pop_front();
                chk("wr_cycle", cyc, e.cyc);
                chk("wr_addr", a2, e.addr);
                chk("wr_data", wd, e.data);
            end else begin
                chk("wr_addr_idle", a2, 0);
                chk("wr_data_idle", wd, 0);
            end
            if (done && exp_done.size() == 0) chk("done_unexpected", done, 0);
            else if (done) begin
                c = exp_done.pop_front();
                chk("done_cycle", cyc, c);
            end
        end
    end

    initial begin
        int  c0, s, d, n;
        bit  f;
        pl_init = 1'b1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        repeat (3) @(posedge clk);
        #1;
        pl_init = 1'b0;
        rst_n   = 1'b1;

        for (int i = 0; i < 4; i++) preload(i, DW'(10 + i));
        run(0, 16, 4, 1'b0, '0, "basic4");
        run(0, 0, 0, 1'b0, '0, "len0");
        run(254, 2, 4, 1'b0, '0, "wrap");
        run(9, 9, 1, 1'b0, '0, "len1");
        run(20, 18, 6, 1'b0, '0, "overlap_down");

        issue(40, 60, 8, 1'b0, '0, 1 << 30, c0);
        @(posedge clk); #1;
        start = 1'b1; src = AW'(100); dst = AW'(41); len = (AW + 1)'(5);
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle("start_while_busy");

        issue(70, 90, 8, 1'b0, '0, 3, c0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_re", re, 0);
        chk("async_rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_idle("reset_mid_copy");
        run(120, 130, 3, 1'b0, '0, "after_reset");

`ifdef BRAM_COPY_FILL_EN
        run(0, 32, 3, 1'b1, 32'hA5A5_A5A5, "fill3");
        run(0, 200, 1, 1'b1, 32'h0BAD_F00D, "fill1");
`endif
        run(7, 7, DEPTH, 1'b0, '0, "full_mem");

        for (int t = 0; t < 25; t++) begin
            n = ($urandom_range(0, 7) == 0) ? 0 : ($urandom_range(0, 9) == 0) ? DEPTH : $urandom_range(1, 40);
            s = $urandom_range(0, DEPTH - 1);
            d = $urandom_range(0, DEPTH - 1);
            for (int k = 0; k < 20 && illegal(s, d, n); k++) d = $urandom_range(0, DEPTH - 1);
            if (illegal(s, d, n)) d = s;
            f = 1'b0;
`ifdef BRAM_COPY_FILL_EN
            f = ($urandom_range(0, 2) == 0);
`endif
            run(s, d, n, f, $urandom, "random");
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
